// File: rtl/alu_md_ctrl.sv
// alu_md_ctrl: ALU select decode plus an iterative multiply/divide sequencer
// that owns the HI/LO registers of the multicycle MIPS core.
// Optional macro: MD_EARLY_TERM_EN (multiply leaves RUN once the remaining
// multiplier bits are all zero; divide latency is unaffected).
module alu_md_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       func,
    input  logic             start,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [2:0]       ALUSel,
    output logic             unsupported,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;

    logic [1:0]         state_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;   // product, or {remainder, quotient}
    logic [2*WIDTH-1:0] opa_reg;   // shifted multiplicand, or divisor in low half
    logic [WIDTH-1:0]   opb_reg;   // remaining multiplier bits
    logic               is_div_reg;
    logic               neg_res_reg;
    logic               neg_rem_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               dz_reg;

    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign div_by_zero = dz_reg;
    assign md_busy     = (state_reg == S_RUN) || (state_reg == S_FIX);
    assign md_done     = (state_reg == S_DONE);

    // ALU select decode; every path lands on a defined select value.
    always_comb begin
        ALUSel      = 3'b010;
        unsupported = 1'b0;
        case (ALUOp)
            2'b00: ALUSel = 3'b010;
            2'b01: ALUSel = 3'b110;
            2'b11: ALUSel = 3'b001;
            default: begin
                case (func)
                    6'h20, 6'h08: ALUSel = 3'b010;
                    6'h22:        ALUSel = 3'b110;
                    6'h24:        ALUSel = 3'b000;
                    6'h25:        ALUSel = 3'b001;
                    6'h2A:        ALUSel = 3'b111;
                    6'h06:        ALUSel = 3'b011;
                    F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO:
                                  ALUSel = 3'b010;
                    default:      unsupported = 1'b1;
                endcase
            end
        endcase
    end

    logic is_mul_op, is_div_op, is_mt_op, signed_op, accept;
    logic rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    assign is_mul_op = (func == F_MULT) || (func == F_MULTU);
    assign is_div_op = (func == F_DIV)  || (func == F_DIVU);
    assign is_mt_op  = (func == F_MTHI) || (func == F_MTLO);
    assign signed_op = (func == F_MULT) || (func == F_DIV);
    assign accept    = start && (ALUOp == 2'b10) &&
                       ((state_reg == S_IDLE) || (state_reg == S_DONE)) &&
                       (is_mul_op || is_div_op || is_mt_op);
    assign rs_neg    = signed_op && rs_val[WIDTH-1];
    assign rt_neg    = signed_op && rt_val[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_val : rs_val;
    assign rt_mag    = rt_neg ? -rt_val : rt_val;

    // One iteration of shift-add multiply and restoring divide.
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH:0]     rem_sh, trial;
    logic               run_last;

    assign mul_next = opb_reg[0] ? (acc_reg + opa_reg) : acc_reg;
    assign rem_sh   = acc_reg[2*WIDTH-1:WIDTH-1];
    assign trial    = rem_sh - {1'b0, opa_reg[WIDTH-1:0]};
    assign div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};
`ifdef MD_EARLY_TERM_EN
    assign run_last = (cnt_reg == LAST_BIT) ||
                      (!is_div_reg && (opb_reg[WIDTH-1:1] == '0));
`else
    assign run_last = (cnt_reg == LAST_BIT);
`endif

    // Sign fix-up applied to the magnitude results before they reach HI/LO.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

    assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;
    assign quo_fix  = neg_res_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fix  = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    assign fix_hi   = is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div_reg ? quo_fix : prod_fix[WIDTH-1:0];

    // Sequencer state, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            opa_reg     <= '0;
            opb_reg     <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            dz_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    acc_reg <= is_div_reg ? div_next : mul_next;
                    opa_reg <= is_div_reg ? opa_reg : (opa_reg << 1);
                    opb_reg <= opb_reg >> 1;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (run_last) state_reg <= S_FIX;
                end
                S_FIX: begin
                    // A zero divisor leaves HI/LO as they were.
                    if (!dz_reg) begin
                        hi_reg <= fix_hi;
                        lo_reg <= fix_lo;
                    end
                    state_reg <= S_DONE;
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase

            // Acceptance only happens in IDLE/DONE, so it never races RUN/FIX work.
            if (accept) begin
                if (is_mt_op) begin
                    if (func == F_MTHI) hi_reg <= rs_val;
                    else                lo_reg <= rs_val;
                    state_reg <= S_IDLE;
                end else begin
                    cnt_reg     <= '0;
                    is_div_reg  <= is_div_op;
                    neg_res_reg <= rs_neg ^ rt_neg;
                    neg_rem_reg <= rs_neg;
                    opb_reg     <= rt_mag;
                    if (is_div_op) begin
                        acc_reg   <= {{WIDTH{1'b0}}, rs_mag};
                        opa_reg   <= {{WIDTH{1'b0}}, rt_mag};
                        dz_reg    <= (rt_val == '0);
                        state_reg <= (rt_val == '0) ? S_FIX : S_RUN;
                    end else begin
                        acc_reg   <= '0;
                        opa_reg   <= {{WIDTH{1'b0}}, rs_mag};
                        dz_reg    <= 1'b0;
                        state_reg <= S_RUN;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_md_ctrl.sv
// Bench for alu_md_ctrl: decode table, multiply/divide vector table checked
// through a scoreboard, and hand-written multi-cycle corner sequences.
module tb_alu_md_ctrl;
    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        ALUOp;
    logic [5:0]        func;
    logic              start;
    logic [WIDTH-1:0]  rs_val, rt_val;
    logic [2:0]        ALUSel;
    logic              unsupported, md_busy, md_done, div_by_zero;
    logic [WIDTH-1:0]  hi, lo;

    always #5 clk = ~clk;

    alu_md_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .func(func), .start(start),
        .rs_val(rs_val), .rt_val(rt_val), .ALUSel(ALUSel),
        .unsupported(unsupported), .md_busy(md_busy), .md_done(md_done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    typedef struct { logic [1:0] aluop; logic [5:0] f; logic [2:0] sel; logic unsup; } dec_vec_t;
    typedef struct { logic [5:0] f; logic [31:0] rs, rt, ehi, elo; logic edz; } md_vec_t;
    typedef struct { logic [31:0] ehi, elo; logic edz; int lat; } exp_t;

    exp_t sb[$];
    int applied = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        applied++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges after the accept edge until md_done is visible.
    function automatic int exp_lat(input logic [5:0] f, input logic [31:0] rt);
`ifdef MD_EARLY_TERM_EN
        logic [31:0] m;
        int rc;
`endif
        if (f == 6'h1A || f == 6'h1B) return (rt == 0) ? 1 : WIDTH + 1;
`ifdef MD_EARLY_TERM_EN
        m  = (f == 6'h18 && rt[31]) ? -rt : rt;
        rc = 1;
        for (int i = 0; i < WIDTH; i++) if (m[i]) rc = i + 1;
        return rc + 1;
`else
        return WIDTH + 1;
`endif
    endfunction

    task automatic push_exp(input md_vec_t v);
        exp_t e;
        e.ehi = v.ehi; e.elo = v.elo; e.edz = v.edz; e.lat = exp_lat(v.f, v.rt);
        sb.push_back(e);
    endtask

    // Drive a request for one clock; returns after the accept edge.
    task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ALUOp = 2'b10; func = f; rs_val = a; rt_val = b; start = 1'b1;
        tick();
        start = 1'b0; ALUOp = 2'b00;
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!md_done && lat < 100) begin
            tick();
            lat++;
        end
        if (!md_done) check("done_timeout", 64'(md_done), 64'd1);
    endtask

    task automatic pop_compare(input string tag, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_hi"},  64'(hi),  64'(e.ehi));
            check({tag, "_lo"},  64'(lo),  64'(e.elo));
            check({tag, "_dz"},  64'(div_by_zero), 64'(e.edz));
            check({tag, "_lat"}, 64'(lat), 64'(e.lat));
            check({tag, "_busy_in_done"}, 64'(md_busy), 64'd0);
        end
        $display("md %s: hi=%h lo=%h dz=%0d lat=%0d", tag, hi, lo, div_by_zero, lat);
    endtask

    dec_vec_t dec_tab[14];
    md_vec_t  md_tab[10];

    initial begin
        int lat;
        int pulses;

        dec_tab[0]  = '{2'b00, 6'h00, 3'b010, 1'b0};
        dec_tab[1]  = '{2'b01, 6'h3F, 3'b110, 1'b0};
        dec_tab[2]  = '{2'b11, 6'h00, 3'b001, 1'b0};
        dec_tab[3]  = '{2'b10, 6'h20, 3'b010, 1'b0};
        dec_tab[4]  = '{2'b10, 6'h22, 3'b110, 1'b0};
        dec_tab[5]  = '{2'b10, 6'h24, 3'b000, 1'b0};
        dec_tab[6]  = '{2'b10, 6'h25, 3'b001, 1'b0};
        dec_tab[7]  = '{2'b10, 6'h2A, 3'b111, 1'b0};
        dec_tab[8]  = '{2'b10, 6'h06, 3'b011, 1'b0};
        dec_tab[9]  = '{2'b10, 6'h08, 3'b010, 1'b0};
        dec_tab[10] = '{2'b10, 6'h1B, 3'b010, 1'b0};
        dec_tab[11] = '{2'b10, 6'h13, 3'b010, 1'b0};
        dec_tab[12] = '{2'b10, 6'h3F, 3'b010, 1'b1};
        dec_tab[13] = '{2'b10, 6'h00, 3'b010, 1'b1};

        md_tab[0] = '{6'h18, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        md_tab[1] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        md_tab[2] = '{6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        md_tab[3] = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        md_tab[4] = '{6'h1B, 32'h00000007, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1};
        md_tab[5] = '{6'h18, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0};
        md_tab[6] = '{6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        md_tab[7] = '{6'h19, 32'h00000003, 32'h00000001, 32'h00000000, 32'h00000003, 1'b0};
        md_tab[8] = '{6'h1B, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        md_tab[9] = '{6'h1A, 32'h00000005, 32'h00000000, 32'h0000000F, 32'h0FFFFFFF, 1'b1};

        rst = 1'b1; ALUOp = 2'b00; func = 6'h00; start = 1'b0;
        rs_val = '0; rt_val = '0;
        tick(); tick();
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(md_busy), 64'd0);
        check("rst_done", 64'(md_done), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        tick();

        // Combinational decode table.
        for (int i = 0; i < 14; i++) begin
            ALUOp = dec_tab[i].aluop; func = dec_tab[i].f;
            #1;
            check($sformatf("dec%0d_sel", i), 64'(ALUSel), 64'(dec_tab[i].sel));
            check($sformatf("dec%0d_unsup", i), 64'(unsupported), 64'(dec_tab[i].unsup));
            $display("dec aluop=%b func=%h -> sel=%b unsup=%0d", ALUOp, func, ALUSel, unsupported);
        end
        ALUOp = 2'b00;
        tick();

        // MTHI / MTLO write directly at the accept edge.
        start_op(6'h11, 32'hA5A5A5A5, 32'h0);
        check("mthi_hi", 64'(hi), 64'hA5A5A5A5);
        check("mthi_busy", 64'(md_busy), 64'd0);
        check("mthi_done", 64'(md_done), 64'd0);
        start_op(6'h13, 32'h5A5A5A5A, 32'h0);
        check("mtlo_lo", 64'(lo), 64'h5A5A5A5A);
        check("mtlo_hi_kept", 64'(hi), 64'hA5A5A5A5);
        tick();
        check("mt_no_done", 64'(md_done), 64'd0);
        $display("mt hi=%h lo=%h", hi, lo);

        // Multiply/divide vector table through the scoreboard.
        for (int i = 0; i < 10; i++) begin
            push_exp(md_tab[i]);
            start_op(md_tab[i].f, md_tab[i].rs, md_tab[i].rt);
            check($sformatf("v%0d_busy", i), 64'(md_busy), 64'd1);
            wait_done(0, lat);
            pop_compare($sformatf("v%0d", i), lat);
            tick();
            check($sformatf("v%0d_done_pulse", i), 64'(md_done), 64'd0);
        end

        // Back-to-back: second request issued during DONE.
        push_exp('{6'h19, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0});
        start_op(6'h19, 32'h00010000, 32'h00010000);
        wait_done(0, lat);
        pop_compare("b2b_a", lat);
        push_exp('{6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0});
        start_op(6'h1B, 32'd100, 32'd7);
        check("b2b_accept_busy", 64'(md_busy), 64'd1);
        check("b2b_accept_done", 64'(md_done), 64'd0);
        wait_done(0, lat);
        pop_compare("b2b_b", lat);
        tick();

        // A start during RUN is ignored (a zero-divisor DIVU would set dz).
        push_exp('{6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        start_op(6'h1A, 32'hFFFFFFF9, 32'h00000002);
        repeat (4) tick();
        start_op(6'h1B, 32'h00000009, 32'h00000000);
        check("ign_busy", 64'(md_busy), 64'd1);
        check("ign_dz", 64'(div_by_zero), 64'd0);
        wait_done(5, lat);
        pop_compare("ignored_start", lat);
        pulses = 0;
        repeat (40) begin
            tick();
            if (md_done) pulses++;
        end
        check("ign_single_done", 64'(pulses), 64'd0);

        // Reset in the middle of RUN aborts the operation.
        start_op(6'h1A, 32'h00001234, 32'h00000003);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", 64'(md_busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            tick();
            if (md_done) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
